// File: rtl/mem_bus_bridge.sv
// CPU-to-slave-channel memory bridge: decodes a channel from the address, performs
// one byte/half/word access per request, and returns right-aligned load data.
module mem_bus_bridge #(
  parameter int NCH      = 4,
  parameter int CH_SHIFT = 28,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic              cpu_wen,
  input  logic              cpu_ren,
  input  logic [1:0]        cpu_mask,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic [31:0]       ch_addr,
  output logic              ch_wen,
  output logic [3:0]        ch_wstrb,
  output logic [31:0]       ch_wdata,
  output logic [NCH-1:0]    ch_sel,
  input  logic [NCH*32-1:0] ch_rdata,
  input  logic [NCH-1:0]    ch_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [4:0] NCH_L      = 5'(NCH);
  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_nx;
  logic [1:0]  mask_q;
  logic        wr_q, err_q, err_nx, latch_en;
  logic [7:0]  cnt, cnt_nx;
  logic        req, fault_in, sel_ready;
  logic [3:0]  idx_in, idx_q;
  logic [31:0] sel_rdata;

  function automatic logic fault_chk(input logic [1:0] a, input logic [1:0] m,
                                     input logic [3:0] idx);
    return ({1'b0, idx} >= NCH_L) || (m == 2'b11) ||
           (m == 2'b01 && a[0]) || (m == 2'b10 && a != 2'b00);
  endfunction

  function automatic logic [3:0] wstrb_f(input logic [1:0] a, input logic [1:0] m);
    case (m)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [31:0] w, input logic [1:0] m);
    case (m)
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] rdata_f(input logic [31:0] d, input logic [1:0] a,
                                          input logic [1:0] m);
    logic [31:0] s;
    s = d >> {a, 3'b000};
    case (m)
      2'b00:   return {24'h0, s[7:0]};
      2'b01:   return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  assign req      = cpu_wen | cpu_ren;
  assign idx_in   = cpu_addr[CH_SHIFT+3:CH_SHIFT];
  assign idx_q    = addr_q[CH_SHIFT+3:CH_SHIFT];
  assign fault_in = fault_chk(cpu_addr[1:0], cpu_mask, idx_in);

  // Channel mux; indices at or above NCH never reach ACCESS, so they select nothing.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    ch_sel    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_q == 4'(i)) begin
        sel_ready = ch_ready[i];
        sel_rdata = ch_rdata[i*32 +: 32];
        ch_sel[i] = (state == ACCESS);
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rdata_nx = rdata_q;
    err_nx   = 1'b0;
    latch_en = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          latch_en = 1'b1;
          if (fault_in) begin
            state_nx = DONE;
            err_nx   = 1'b1;
            rdata_nx = '0;
          end else begin
            state_nx = ACCESS;
            cnt_nx   = '0;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          state_nx = DONE;
          if (!wr_q) rdata_nx = rdata_f(sel_rdata, addr_q[1:0], mask_q);
        end else if (cnt == TIMEOUT_M1) begin
          state_nx = DONE;
          err_nx   = 1'b1;
          rdata_nx = '0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
      if (latch_en) begin
        addr_q  <= cpu_addr;
        mask_q  <= cpu_mask;
        wdata_q <= cpu_wdata;
        wr_q    <= cpu_wen;
      end
    end
  end

  // err_q is only ever set on the edge entering DONE, so it is a one-cycle pulse.
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign cpu_stall = !rst && (((state == IDLE) && req) || (state == ACCESS));
  assign ch_addr   = {addr_q[31:2], 2'b00};
  assign ch_wen    = (state == ACCESS) && wr_q;
  assign ch_wstrb  = ((state == ACCESS) && wr_q) ? wstrb_f(addr_q[1:0], mask_q) : 4'b0000;
  assign ch_wdata  = wdata_f(wdata_q, mask_q);

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard bench for mem_bus_bridge: stimulus queues expected channel-side and
// CPU-side responses, a negedge monitor pops and compares them.
module tb_mem_bus_bridge;

  localparam int NCH = 4;
  localparam int TO  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata, ch_addr, ch_wdata;
  logic              cpu_wen, cpu_ren, cpu_stall, cpu_err, ch_wen;
  logic [1:0]        cpu_mask;
  logic [3:0]        ch_wstrb;
  logic [NCH-1:0]    ch_sel, ch_ready;
  logic [NCH*32-1:0] ch_rdata;

  mem_bus_bridge #(.NCH(NCH), .CH_SHIFT(28), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen), .cpu_ren(cpu_ren),
    .cpu_mask(cpu_mask), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_err(cpu_err), .ch_addr(ch_addr), .ch_wen(ch_wen),
    .ch_wstrb(ch_wstrb), .ch_wdata(ch_wdata), .ch_sel(ch_sel), .ch_rdata(ch_rdata),
    .ch_ready(ch_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        rchk;
    int          stall;
  } resp_t;

  bus_t  bus_q[$];
  resp_t resp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  logic stim_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  int         stall_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_sel = 4'b0;
  logic       rst_prev = 1'b0;
  logic       final_chk = 1'b0;

  always @(negedge clk) begin
    bus_t  b;
    resp_t r;
    if (rst) begin
      stall_cnt  = 0;
      prev_stall = 1'b0;
      prev_sel   = 4'b0;
      rst_prev   = 1'b1;
    end else begin
      if (rst_prev) begin
        chk("post_rst_sel", 32'(ch_sel), 32'h0);
        chk("post_rst_err", 32'(cpu_err), 32'h0);
        chk("post_rst_rdata", cpu_rdata, 32'h0);
      end
      rst_prev = 1'b0;
      if (ch_sel != 4'b0 && prev_sel == 4'b0) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_sel", 32'(ch_sel), 32'h0);
        end else begin
          b = bus_q.pop_front();
          chk("ch_sel", 32'(ch_sel), 32'(b.sel));
          chk("ch_addr", ch_addr, b.addr);
          chk("ch_wen", 32'(ch_wen), 32'(b.wen));
          if (b.wen) begin
            chk("ch_wstrb", 32'(ch_wstrb), 32'(b.wstrb));
            chk("ch_wdata", ch_wdata, b.wdata);
          end
        end
      end
      if (cpu_stall) begin
        stall_cnt++;
      end else if (prev_stall) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_done", 32'(stall_cnt), 32'h0);
        end else begin
          r = resp_q.pop_front();
          chk("cpu_err", 32'(cpu_err), 32'(r.err));
          if (r.rchk) chk("cpu_rdata", cpu_rdata, r.rdata);
          chk("stall_cycles", 32'(stall_cnt), 32'(r.stall));
        end
        stall_cnt = 0;
      end else begin
        chk("idle_err", 32'(cpu_err), 32'h0);
      end
      prev_stall = cpu_stall;
      prev_sel   = ch_sel;
    end
    if (stim_done && !final_chk) begin
      final_chk = 1'b1;
      chk("bus_q_left", 32'(bus_q.size()), 32'h0);
      chk("resp_q_left", 32'(resp_q.size()), 32'h0);
    end
  end

  // nwait >= 0: ready after nwait ACCESS cycles; nwait < 0: never ready (timeout).
  // e_sel == 0 marks a request expected to fault without touching a channel.
  task automatic xfer(input logic [31:0] addr, input logic wen, input logic ren,
                      input logic [1:0] mask, input logic [31:0] wdata, input int ch,
                      input logic [31:0] rword, input int nwait, input logic [3:0] e_sel,
                      input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
                      input logic [31:0] e_rdata, input logic e_err, input logic e_rchk);
    bus_t     b;
    resp_t    r;
    logic     fault;
    logic [3:0] noise;
    fault = (e_sel == 4'b0);
    noise = ~(4'(1) << ch);
    for (int i = 0; i < NCH; i++) ch_rdata[i*32 +: 32] = 32'hDEAD_0000 | 32'(i);
    ch_rdata[ch*32 +: 32] = rword;
    if (!fault) begin
      b = '{sel: e_sel, addr: addr & 32'hFFFF_FFFC, wen: wen, wstrb: e_wstrb, wdata: e_wdata};
      bus_q.push_back(b);
    end
    r = '{rdata: e_rdata, err: e_err, rchk: e_rchk,
          stall: fault ? 1 : (nwait < 0 ? 1 + TO : 2 + nwait)};
    resp_q.push_back(r);
    @(posedge clk); #1;
    cpu_addr = addr; cpu_wen = wen; cpu_ren = ren; cpu_mask = mask; cpu_wdata = wdata;
    @(posedge clk); #1;
    cpu_wen = 1'b0; cpu_ren = 1'b0;
    if (!fault) begin
      if (nwait < 0) begin
        ch_ready = noise;
        repeat (TO) begin @(posedge clk); #1; end
        ch_ready = '0;
      end else begin
        repeat (nwait) begin
          ch_ready = noise;
          @(posedge clk); #1;
        end
        ch_ready = 4'(1) << ch;
        @(posedge clk); #1;
        ch_ready = '0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus_t b;
    rst = 1'b1;
    cpu_addr = '0; cpu_wen = 1'b0; cpu_ren = 1'b0; cpu_mask = 2'b00; cpu_wdata = '0;
    ch_ready = '0; ch_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    //    addr          wen   ren   mask   wdata         ch rword         wait sel     strb     e_wdata       e_rdata       err   rchk
    xfer(32'h1000_0004, 1'b0, 1'b1, 2'b10, 32'h0,        1, 32'hCAFEBABE, 0, 4'b0010, 4'b0000, 32'h0,        32'hCAFEBABE, 1'b0, 1'b1);
    xfer(32'h0000_0003, 1'b1, 1'b0, 2'b00, 32'h5A,       0, 32'h0,        0, 4'b0001, 4'b1000, 32'h5A5A5A5A, 32'h0,        1'b0, 1'b0);
    xfer(32'h2000_0002, 1'b0, 1'b1, 2'b01, 32'h0,        2, 32'h1234ABCD, 1, 4'b0100, 4'b0000, 32'h0,        32'h00001234, 1'b0, 1'b1);
    xfer(32'h7000_0000, 1'b0, 1'b1, 2'b10, 32'h0,        0, 32'h0,        0, 4'b0000, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b1);
    xfer(32'h0000_0001, 1'b0, 1'b1, 2'b01, 32'h0,        0, 32'h0,        0, 4'b0000, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b1);
    xfer(32'h3000_0001, 1'b0, 1'b1, 2'b00, 32'h0,        3, 32'h11223344, 0, 4'b1000, 4'b0000, 32'h0,        32'h00000033, 1'b0, 1'b1);
    xfer(32'h3000_0000, 1'b0, 1'b1, 2'b10, 32'h0,        3, 32'h55667788, -1, 4'b1000, 4'b0000, 32'h0,       32'h0,        1'b1, 1'b1);
    xfer(32'h1000_0002, 1'b1, 1'b0, 2'b01, 32'hFFFFBEEF, 1, 32'h0,        2, 4'b0010, 4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0, 1'b0);
    xfer(32'h2000_0008, 1'b1, 1'b1, 2'b10, 32'h01234567, 2, 32'h0,        0, 4'b0100, 4'b1111, 32'h01234567, 32'h0,        1'b0, 1'b0);
    xfer(32'h0000_0000, 1'b0, 1'b1, 2'b11, 32'h0,        0, 32'h0,        0, 4'b0000, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b1);
    xfer(32'h0000_0002, 1'b1, 1'b0, 2'b10, 32'h0,        0, 32'h0,        0, 4'b0000, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b1);
    xfer(32'h0000_0000, 1'b0, 1'b1, 2'b10, 32'h0,        0, 32'hA5A50F0F, 0, 4'b0001, 4'b0000, 32'h0,        32'hA5A50F0F, 1'b0, 1'b1);

    // Reset in the second ACCESS cycle: transfer is abandoned, no response expected.
    b = '{sel: 4'b0010, addr: 32'h1000_0000, wen: 1'b0, wstrb: 4'b0000, wdata: 32'h0};
    bus_q.push_back(b);
    @(posedge clk); #1;
    cpu_addr = 32'h1000_0000; cpu_ren = 1'b1; cpu_mask = 2'b10;
    @(posedge clk); #1;
    cpu_ren = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    xfer(32'h1000_0008, 1'b0, 1'b1, 2'b10, 32'h0,        1, 32'h87654321, 0, 4'b0010, 4'b0000, 32'h0,        32'h87654321, 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    stim_done = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
